// File: rtl/bsg_cache_dma_sram_responder.sv
// Memory-side responder for the bsg_cache DMA interface, backed by a single-port
// synchronous SRAM with one cycle of read latency.
module bsg_cache_dma_sram_responder #(
    parameter int unsigned addr_width_p          = 30,
    parameter int unsigned data_width_p          = 32,
    parameter int unsigned block_size_in_words_p = 8,
    parameter int unsigned els_p                 = 32768
) (
    input  logic                                             clk_i,
    input  logic                                             reset_n_i,

    input  logic [addr_width_p+block_size_in_words_p:0]      dma_pkt_i,
    input  logic                                             dma_pkt_v_i,
    output logic                                             dma_pkt_yumi_o,

    output logic [data_width_p-1:0]                          dma_data_o,
    output logic                                             dma_data_v_o,
    input  logic                                             dma_data_ready_i,

    input  logic [data_width_p-1:0]                          dma_data_i,
    input  logic                                             dma_data_v_i,
    output logic                                             dma_data_yumi_o,

    output logic                                             mem_v_o,
    output logic                                             mem_w_o,
    output logic [$clog2(els_p)-1:0]                         mem_addr_o,
    output logic [data_width_p-1:0]                          mem_data_o,
    input  logic [data_width_p-1:0]                          mem_data_i
);

    localparam int unsigned lg_els_lp   = $clog2(els_p);
    localparam int unsigned lg_block_lp = $clog2(block_size_in_words_p);
    localparam int unsigned lg_bytes_lp = $clog2(data_width_p / 8);
    localparam logic [lg_block_lp:0] block_cnt_lp = (lg_block_lp+1)'(block_size_in_words_p);
    localparam logic [lg_block_lp:0] last_word_lp = (lg_block_lp+1)'(block_size_in_words_p - 1);

    typedef enum logic [1:0] {StIdle, StRead, StWrite} state_e;

    logic                             pkt_write;
    logic [addr_width_p-1:0]          pkt_addr;
    logic [block_size_in_words_p-1:0] pkt_mask;
    logic [lg_els_lp-1:0]             pkt_base;

    assign {pkt_write, pkt_addr, pkt_mask} = dma_pkt_i;

    // Byte address -> word index, block aligned, then wrapped to the SRAM depth.
    assign pkt_base = {pkt_addr[lg_els_lp+lg_bytes_lp-1:lg_block_lp+lg_bytes_lp],
                       {lg_block_lp{1'b0}}};

    logic unused_addr_bits;
    assign unused_addr_bits = ^{pkt_addr[addr_width_p-1:lg_els_lp+lg_bytes_lp],
                                pkt_addr[lg_block_lp+lg_bytes_lp-1:0]};

    state_e                           state_q, state_d;
    logic [lg_els_lp-1:0]             base_q;
    logic [block_size_in_words_p-1:0] mask_q;
    logic [lg_block_lp:0]             cnt_q, cnt_d;
    logic [lg_block_lp:0]             deq_cnt_q, deq_cnt_d;
    logic                             inflight_q;
    logic [data_width_p-1:0]          fifo_mem_q [2];
    logic                             fifo_rd_q, fifo_wr_q;
    logic [1:0]                       fifo_cnt_q;

    logic                             deq;
    logic                             issue;
    logic [2:0]                       occupancy;
    logic [lg_els_lp-1:0]             word_addr;

    assign word_addr    = base_q | lg_els_lp'(cnt_q[lg_block_lp-1:0]);
    assign dma_data_v_o = (state_q == StRead) && (fifo_cnt_q != 2'd0);
    assign dma_data_o   = fifo_mem_q[fifo_rd_q];
    assign deq          = dma_data_v_o & dma_data_ready_i;

    // Slots committed after this cycle's dequeue; a new read only goes out if one is free.
    assign occupancy = {1'b0, fifo_cnt_q} + {2'b00, inflight_q} - {2'b00, deq};
    assign issue     = (state_q == StRead) && (cnt_q < block_cnt_lp) && (occupancy < 3'd2);

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        deq_cnt_d       = deq_cnt_q;
        dma_pkt_yumi_o  = 1'b0;
        dma_data_yumi_o = 1'b0;
        mem_v_o         = 1'b0;
        mem_w_o         = 1'b0;
        mem_addr_o      = '0;
        mem_data_o      = '0;
        unique case (state_q)
            StIdle: begin
                dma_pkt_yumi_o = dma_pkt_v_i & reset_n_i;
                if (dma_pkt_v_i) begin
                    state_d   = pkt_write ? StWrite : StRead;
                    cnt_d     = '0;
                    deq_cnt_d = '0;
                end
            end
            StRead: begin
                if (issue) begin
                    mem_v_o    = 1'b1;
                    mem_addr_o = word_addr;
                    cnt_d      = cnt_q + 1'b1;
                end
                if (deq) begin
                    deq_cnt_d = deq_cnt_q + 1'b1;
                    if (deq_cnt_q == last_word_lp) begin
                        state_d = StIdle;
                    end
                end
            end
            StWrite: begin
                if (dma_data_v_i) begin
                    dma_data_yumi_o = 1'b1;
                    // Masked-off words are still consumed, just never written.
                    mem_v_o         = mask_q[cnt_q[lg_block_lp-1:0]];
                    mem_w_o         = 1'b1;
                    mem_addr_o      = word_addr;
                    mem_data_o      = dma_data_i;
                    cnt_d           = cnt_q + 1'b1;
                    if (cnt_q == last_word_lp) begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q    <= StIdle;
            base_q     <= '0;
            mask_q     <= '0;
            cnt_q      <= '0;
            deq_cnt_q  <= '0;
            inflight_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            deq_cnt_q  <= deq_cnt_d;
            inflight_q <= issue;
            if (dma_pkt_yumi_o) begin
                base_q <= pkt_base;
                mask_q <= pkt_mask;
            end
        end
    end

    // Two-entry output FIFO; the SRAM word lands here the cycle after its read issues.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            fifo_mem_q[0] <= '0;
            fifo_mem_q[1] <= '0;
            fifo_rd_q     <= 1'b0;
            fifo_wr_q     <= 1'b0;
            fifo_cnt_q    <= 2'd0;
        end else begin
            if (inflight_q) begin
                fifo_mem_q[fifo_wr_q] <= mem_data_i;
                fifo_wr_q             <= ~fifo_wr_q;
            end
            if (deq) begin
                fifo_rd_q <= ~fifo_rd_q;
            end
            fifo_cnt_q <= fifo_cnt_q + {1'b0, inflight_q} - {1'b0, deq};
        end
    end

endmodule

// File: doc/bsg_cache_dma_sram_responder.md
Name: bsg_cache_dma_sram_responder

Overview:
Synthesizable memory-side responder for the cache DMA interface. It accepts bsg_cache DMA packets (block fill reads and evict writes) from a cache such as bsg_cache_lfu, and services them against a single-port synchronous SRAM with 1-cycle read latency. It is the hardware counterpart of the nonsynth DMA model, for FPGA and synth-level benches and real memory backends.

Parameters:
addr_width_p, 30, byte address width of the DMA packet.
data_width_p, 32, DMA data word width.
block_size_in_words_p, 8, number of words per block; also the packet mask width.
els_p, 32768, backing SRAM depth in words; mem_addr width is lg(els_p).

Ports:
clk_i  in  1  clock
reset_n_i  in  1  asynchronous reset, active-low
dma_pkt_i  in  1+addr_width_p+block_size_in_words_p  packet {write_not_read, addr, mask}, MSB to LSB
dma_pkt_v_i  in  1  packet valid
dma_pkt_yumi_o  out  1  packet consumed
dma_data_o  out  data_width_p  fill data to cache
dma_data_v_o  out  1  fill data valid
dma_data_ready_i  in  1  cache ready for fill word
dma_data_i  in  data_width_p  evict data from cache
dma_data_v_i  in  1  evict data valid
dma_data_yumi_o  out  1  evict word consumed
mem_v_o  out  1  SRAM access enable
mem_w_o  out  1  SRAM write (1) / read (0)
mem_addr_o  out  lg(els_p)  SRAM word address
mem_data_o  out  data_width_p  SRAM write data
mem_data_i  in  data_width_p  SRAM read data, valid the cycle after a read

Behaviour:
- Reset (reset_n_i=0, async) clears state to IDLE, clears word counters, the in-flight flag and the output FIFO. All outputs are 0 during reset.
- Address mapping: word index = addr >> lg(data_width_p/8). The low lg(block_size_in_words_p) bits are forced to 0 (block-aligned), then the result is truncated to lg(els_p) bits, so out-of-range addresses wrap.
- Word k of a block goes to mem_addr = base + k, for k = 0..block_size_in_words_p-1.
- State machine:
  - IDLE: dma_pkt_yumi_o = dma_pkt_v_i (combinational). Latch addr, mask and write_not_read. Next state is WRITE or READ.
  - READ: the mask is ignored and all words are fetched.
    - Output path is a 2-entry FIFO plus a 1-bit in-flight flag.
    - Issue read k (mem_v_o=1, mem_w_o=0) when k < block size and (fifo_count + inflight − deq_this_cycle) < 2, where deq = dma_data_v_o & dma_data_ready_i.
    - mem_data_i is enqueued the cycle after an issue.
    - dma_data_v_o = FIFO non-empty; dma_data_o = FIFO head.
    - Leave for IDLE the cycle after the last word is dequeued.
  - WRITE: dma_data_yumi_o = dma_data_v_i.
    - On each yumi, mem_v_o = mask[k] and mem_w_o = 1, with mem_data_o = dma_data_i; k increments.
    - Masked-off words are consumed but not written.
    - Leave for IDLE the cycle after word block_size−1 is consumed.
- Timing (ready held high): yumi at cycle 0 → read word0 issued cycle 1 → dma_data_v_o first high at cycle 3 → one word per cycle through cycle 2+block_size → IDLE the next cycle.
- Write timing: one word per cycle when dma_data_v_i is held high; the SRAM write happens in the same cycle as the yumi.
- dma_pkt_yumi_o is 0 outside IDLE. dma_data_yumi_o is 0 outside WRITE, so evict data arriving early is held off. dma_data_v_o is 0 outside READ.
- Backpressure: dma_data_ready_i low stalls issue once the FIFO plus in-flight count reaches 2. No word is ever dropped or duplicated.
- Packet and evict data presented in the same IDLE cycle: the packet is taken first, and data is consumed from the next cycle onward.
- Reset asserted mid-transfer aborts the transfer immediately. SRAM contents are untouched, apart from any write already completed.

Test Plan:
- Preload SRAM words 0x100..0x107 with 0xA0..0xA7; read pkt addr=0x400, ready=1 → yumi at cycle 0, data 0xA0..0xA7 on cycles 3..10, IDLE at cycle 11.
- Write pkt addr=0x800, mask=0xFF, data 0xB0..0xB7 → SRAM[0x200..0x207]=0xB0..0xB7; dma_data_yumi_o high for exactly 8 cycles.
- Write mask=0x0F over a preloaded 0xCC block → words 0..3 updated, words 4..7 remain 0xCC; all 8 evict words yumi'd.
- Read with ready toggling 1,0,0,1,… → the fill sequence is exactly 8 in-order words, and at most 2 words are buffered or in flight.
- Read pkt addr=0x40000+0x1C (beyond els_p, unaligned) → wraps and aligns to word 0x0000; returns SRAM[0..7].
- Assert reset_n_i=0 at fill word 3 → dma_data_v_o drops immediately; after release the next read pkt returns a full, correct block.
